// File: rtl/chain_addsub.sv
// Multi-precision add/subtract unit: one W-bit word per beat, LS word first,
// with carry chaining between beats and a stored carry/borrow flag between operations.
module chain_addsub #(
  parameter int W         = 8,
  parameter int MAX_WORDS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_first,
  input  logic         in_last,
  input  logic         in_sub,
  input  logic         in_use_cf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_last,
  output logic         out_co,
  output logic         out_zero,
  output logic         out_ovf,
  output logic         cflag,
  output logic         err
);

  localparam int CW = $clog2(MAX_WORDS + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;

  logic          sub_q, carry_q, zero_q;
  logic          accept, start, eff_sub, ci, raw_co, co;
  logic          forced_last, is_last, zero_now, ovf, proto_err;
  logic [W-1:0]  b_eff, sum;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // A beat starts a new operation when nothing is running or when it claims to be first.
  assign start   = (state == IDLE) | in_first;
  assign eff_sub = start ? in_sub : sub_q;
  assign b_eff   = eff_sub ? ~in_b : in_b;
  assign ci      = start ? (in_sub ^ (in_use_cf & cflag)) : carry_q;

  assign {raw_co, sum} = {1'b0, in_a} + {1'b0, b_eff} + {{W{1'b0}}, ci};
  assign co            = eff_sub ^ raw_co;

  assign forced_last = (state == RUN) & ~in_first & ~in_last & (count == CW'(MAX_WORDS - 1));
  assign is_last     = in_last | forced_last;
  assign zero_now    = (sum == '0) & (start | zero_q);
  assign ovf         = is_last & (in_a[W-1] == b_eff[W-1]) & (sum[W-1] != in_a[W-1]);
  assign proto_err   = ((state == IDLE) & ~in_first) | ((state == RUN) & in_first) | forced_last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (accept) begin
      if (is_last) begin
        state_nxt = IDLE;
        count_nxt = '0;
      end else if (start) begin
        state_nxt = RUN;
        count_nxt = CW'(1);
      end else begin
        state_nxt = RUN;
        count_nxt = count + CW'(1);
      end
    end
  end

  // Single-entry output register; it only reloads when the previous word is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_co    <= 1'b0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      cflag     <= 1'b0;
      err       <= 1'b0;
      sub_q     <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_sum   <= sum;
      out_last  <= is_last;
      out_co    <= co;
      out_zero  <= zero_now;
      out_ovf   <= ovf;
      carry_q   <= raw_co;
      zero_q    <= zero_now;
      if (start)     sub_q <= in_sub;
      if (is_last)   cflag <= co;
      if (proto_err) err   <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
